// File: rtl/gpr_file_mp.sv
// Multi-port general-purpose register file: NUM_RD combinational reads, two byte-masked
// write ports with optional same-cycle bypass, a per-register busy scoreboard and a post-reset clear sweep.
module gpr_file_mp #(
    parameter int XLEN     = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     init_done,
    input  logic                     wen0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [XLEN-1:0]          wdata0,
    input  logic [XLEN/8-1:0]        wmask0,
    input  logic                     wen1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [XLEN-1:0]          wdata1,
    input  logic [XLEN/8-1:0]        wmask1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*XLEN-1:0]   rdata,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     busy_set,
    input  logic [ADDR_W-1:0]        busy_addr
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = XLEN / 8;

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [XLEN-1:0]   regs_q [DEPTH];
    logic [DEPTH-1:0]  hit0_v, hit1_v;
    logic              run, we0, we1;

    // Port 1 owns any byte it enables; port 0 fills the remaining enabled bytes.
    function automatic logic [XLEN-1:0] merge(
        input logic [XLEN-1:0] old,
        input logic            h0,
        input logic [XLEN-1:0] d0,
        input logic [NB-1:0]   m0,
        input logic            h1,
        input logic [XLEN-1:0] d1,
        input logic [NB-1:0]   m1
    );
        logic [XLEN-1:0] r;
        r = old;
        for (int b = 0; b < NB; b++) begin
            if (h1 && m1[b])
                r[b*8 +: 8] = d1[b*8 +: 8];
            else if (h0 && m0[b])
                r[b*8 +: 8] = d0[b*8 +: 8];
        end
        return r;
    endfunction

    assign run       = (state_q == S_RUN);
    assign we0       = run && wen0 && !(ZERO_REG != 0 && waddr0 == '0);
    assign we1       = run && wen1 && !(ZERO_REG != 0 && waddr1 == '0);
    assign init_done = init_done_q;

    always_comb begin
        hit0_v = '0;
        hit1_v = '0;
        for (int a = 0; a < DEPTH; a++) begin
            hit0_v[a] = we0 && (waddr0 == ADDR_W'(a));
            hit1_v[a] = we1 && (waddr1 == ADDR_W'(a));
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        busy_d      = busy_q;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end
            end
            S_RUN: begin
                // Set is applied after clear so an issue in the writeback cycle keeps the register pending.
                for (int a = 0; a < DEPTH; a++) begin
                    if (hit0_v[a] || hit1_v[a])
                        busy_d[a] = 1'b0;
                    if (busy_set && busy_addr == ADDR_W'(a) && !(ZERO_REG != 0 && a == 0))
                        busy_d[a] = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            regs_q[cnt_q] <= '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (hit0_v[a] || hit1_v[a])
                    regs_q[a] <= merge(regs_q[a], hit0_v[a], wdata0, wmask0,
                                       hit1_v[a], wdata1, wmask1);
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic              byp;
        rdata   = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra  = raddr[i*ADDR_W +: ADDR_W];
            byp = (BYPASS != 0) && (hit0_v[ra] || hit1_v[ra]);
            if (run && !(ZERO_REG != 0 && ra == '0)) begin
                rdata[i*XLEN +: XLEN] = byp ? merge(regs_q[ra], hit0_v[ra], wdata0, wmask0,
                                                    hit1_v[ra], wdata1, wmask1)
                                            : regs_q[ra];
                rd_busy[i] = busy_q[ra] && !byp;
            end
        end
    end
endmodule

// File: tb/tb_gpr_file_mp.sv
// Bench for gpr_file_mp: init sweep timing, table of read/write/busy vectors via a scoreboard queue,
// a no-bypass instance for forwarding contrast, and reset during the sweep.
module tb_gpr_file_mp;
    localparam int XLEN = 64;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            wen0, wen1, busy_set;
    logic [AW-1:0]   waddr0, waddr1, busy_addr;
    logic [XLEN-1:0] wdata0, wdata1;
    logic [7:0]      wmask0, wmask1;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata, rdata_nb;
    logic [NRD-1:0]      rd_busy, rd_busy_nb;
    logic                init_done, init_done_nb;

    gpr_file_mp #(.XLEN(XLEN), .ADDR_W(AW), .NUM_RD(NRD), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0), .wmask0(wmask0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1), .wmask1(wmask1),
        .raddr(raddr), .rdata(rdata), .rd_busy(rd_busy),
        .busy_set(busy_set), .busy_addr(busy_addr)
    );

    gpr_file_mp #(.XLEN(XLEN), .ADDR_W(AW), .NUM_RD(NRD), .BYPASS(0), .ZERO_REG(1)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .init_done(init_done_nb),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0), .wmask0(wmask0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1), .wmask1(wmask1),
        .raddr(raddr), .rdata(rdata_nb), .rd_busy(rd_busy_nb),
        .busy_set(busy_set), .busy_addr(busy_addr)
    );

    typedef struct {
        logic            w0;
        logic [AW-1:0]   a0;
        logic [XLEN-1:0] d0;
        logic [7:0]      m0;
        logic            w1;
        logic [AW-1:0]   a1;
        logic [XLEN-1:0] d1;
        logic [7:0]      m1;
        logic            bs;
        logic [AW-1:0]   ba;
        logic [AW-1:0]   ra0;
        logic [AW-1:0]   ra1;
        logic [XLEN-1:0] e0;
        logic [XLEN-1:0] e1;
        logic            eb0;
        logic            eb1;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0] e0;
        logic [XLEN-1:0] e1;
        logic            eb0;
        logic            eb1;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(
        input logic w0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0, input logic [7:0] m0,
        input logic w1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1, input logic [7:0] m1,
        input logic bs, input logic [AW-1:0] ba, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
        input logic [XLEN-1:0] e0, input logic [XLEN-1:0] e1, input logic eb0, input logic eb1);
        vec_t v;
        v.w0 = w0; v.a0 = a0; v.d0 = d0; v.m0 = m0;
        v.w1 = w1; v.a1 = a1; v.d1 = d1; v.m1 = m1;
        v.bs = bs; v.ba = ba; v.ra0 = ra0; v.ra1 = ra1;
        v.e0 = e0; v.e1 = e1; v.eb0 = eb0; v.eb1 = eb1;
        return v;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        wen0 = 0; waddr0 = '0; wdata0 = '0; wmask0 = '0;
        wen1 = 0; waddr1 = '0; wdata1 = '0; wmask1 = '0;
        busy_set = 0; busy_addr = '0; raddr = '0;
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        wen0 = v.w0; waddr0 = v.a0; wdata0 = v.d0; wmask0 = v.m0;
        wen1 = v.w1; waddr1 = v.a1; wdata1 = v.d1; wmask1 = v.m1;
        busy_set = v.bs; busy_addr = v.ba; raddr = {v.ra1, v.ra0};
        e.e0 = v.e0; e.e1 = v.e1; e.eb0 = v.eb0; e.eb1 = v.eb1;
        sb_q.push_back(e);
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (init_done) break;
        end
        check(name, 64'(n), 64'd32);
    endtask

    initial begin
        //                w0 a0  d0                      m0     w1 a1  d1                      m1     bs ba  ra0 ra1 e0                      e1                      b0 b1
        vecs.push_back(mk(0, 0,  64'h0,                  8'h00, 0, 0,  64'h0,                  8'h00, 0, 0,  4,  0,  64'h0,                  64'h0,                  0, 0));
        vecs.push_back(mk(1, 5,  64'h1122334455667788,   8'hFF, 0, 0,  64'h0,                  8'h00, 0, 0,  5,  6,  64'h1122334455667788,   64'h0,                  0, 0));
        vecs.push_back(mk(0, 0,  64'h0,                  8'h00, 0, 0,  64'h0,                  8'h00, 0, 0,  5,  4,  64'h1122334455667788,   64'h0,                  0, 0));
        vecs.push_back(mk(1, 5,  64'hAAAAAAAAAAAAAAAA,   8'h0F, 0, 0,  64'h0,                  8'h00, 0, 0,  5,  3,  64'h11223344AAAAAAAA,   64'h0,                  0, 0));
        vecs.push_back(mk(0, 0,  64'h0,                  8'h00, 0, 0,  64'h0,                  8'h00, 0, 0,  5,  5,  64'h11223344AAAAAAAA,   64'h11223344AAAAAAAA,   0, 0));
        vecs.push_back(mk(0, 0,  64'h0,                  8'h00, 1, 7,  64'h42,                 8'hFF, 0, 0,  7,  7,  64'h42,                 64'h42,                 0, 0));
        vecs.push_back(mk(1, 3,  64'h1,                  8'hFF, 1, 3,  64'hFF,                 8'h01, 0, 0,  3,  7,  64'hFF,                 64'h42,                 0, 0));
        vecs.push_back(mk(0, 0,  64'h0,                  8'h00, 0, 0,  64'h0,                  8'h00, 0, 0,  3,  5,  64'hFF,                 64'h11223344AAAAAAAA,   0, 0));
        vecs.push_back(mk(0, 0,  64'h0,                  8'h00, 0, 0,  64'h0,                  8'h00, 1, 9,  9,  9,  64'h0,                  64'h0,                  0, 0));
        vecs.push_back(mk(0, 0,  64'h0,                  8'h00, 0, 0,  64'h0,                  8'h00, 0, 0,  9,  8,  64'h0,                  64'h0,                  1, 0));
        vecs.push_back(mk(1, 9,  64'h55,                 8'hFF, 0, 0,  64'h0,                  8'h00, 1, 9,  9,  9,  64'h55,                 64'h55,                 0, 0));
        vecs.push_back(mk(0, 0,  64'h0,                  8'h00, 0, 0,  64'h0,                  8'h00, 0, 0,  9,  1,  64'h55,                 64'h0,                  1, 0));
        vecs.push_back(mk(1, 9,  64'h66,                 8'h00, 0, 0,  64'h0,                  8'h00, 0, 0,  9,  9,  64'h55,                 64'h55,                 0, 0));
        vecs.push_back(mk(0, 0,  64'h0,                  8'h00, 0, 0,  64'h0,                  8'h00, 0, 0,  9,  9,  64'h55,                 64'h55,                 0, 0));
        vecs.push_back(mk(1, 0,  64'hDEAD,               8'hFF, 0, 0,  64'h0,                  8'h00, 1, 0,  0,  0,  64'h0,                  64'h0,                  0, 0));
        vecs.push_back(mk(0, 0,  64'h0,                  8'h00, 0, 0,  64'h0,                  8'h00, 0, 0,  0,  9,  64'h0,                  64'h55,                 0, 0));
        vecs.push_back(mk(1, 10, 64'h1010,               8'h03, 1, 11, 64'hFFFFFFFFFFFFFFFF,   8'h80, 0, 0,  10, 11, 64'h1010,               64'hFF00000000000000,   0, 0));
        vecs.push_back(mk(0, 0,  64'h0,                  8'h00, 0, 0,  64'h0,                  8'h00, 0, 0,  10, 11, 64'h1010,               64'hFF00000000000000,   0, 0));
        vecs.push_back(mk(0, 0,  64'h0,                  8'h00, 1, 31, 64'h7,                  8'h01, 1, 31, 30, 31, 64'h0,                  64'h7,                  0, 0));
        vecs.push_back(mk(0, 0,  64'h0,                  8'h00, 0, 0,  64'h0,                  8'h00, 0, 0,  30, 31, 64'h0,                  64'h7,                  0, 1));

        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Writes and busy issue during the sweep must be ignored.
        wen0 = 1; waddr0 = 5'd4; wdata0 = '1; wmask0 = 8'hFF;
        busy_set = 1; busy_addr = 5'd4; raddr = {5'd4, 5'd4};
        #2;
        check("reset_init_done", 64'(init_done), 64'd0);
        check("init_rdata0", rdata[63:0], 64'h0);
        check("init_rd_busy", 64'(rd_busy), 64'd0);
        wait_init("init_cycles");
        idle();

        for (int k = 0; k < vecs.size(); k++) begin
            exp_t e;
            @(negedge clk);
            apply(vecs[k]);
            #2;
            e = sb_q.pop_front();
            check($sformatf("row%0d_rdata0", k), rdata[63:0], e.e0);
            check($sformatf("row%0d_rdata1", k), rdata[127:64], e.e1);
            check($sformatf("row%0d_busy0", k), 64'(rd_busy[0]), 64'(e.eb0));
            check($sformatf("row%0d_busy1", k), 64'(rd_busy[1]), 64'(e.eb1));
        end

        @(negedge clk);
        idle();
        wen1 = 1; waddr1 = 5'd12; wdata1 = 64'h42; wmask1 = 8'hFF; raddr = {5'd12, 5'd12};
        #2;
        check("bypass_on_rdata1", rdata[127:64], 64'h42);
        check("bypass_off_rdata1", rdata_nb[127:64], 64'h0);
        @(negedge clk);
        idle();
        raddr = {5'd12, 5'd12};
        #2;
        check("nobyp_after_write", rdata_nb[127:64], 64'h42);

        @(negedge clk);
        idle();
        raddr = {5'd31, 5'd5};
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("run_reset_init_done", 64'(init_done), 64'd0);
        check("run_reset_rdata0", rdata[63:0], 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("mid_init_not_done", 64'(init_done), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("restart_cycles");
        @(negedge clk);
        raddr = {5'd31, 5'd5};
        #2;
        check("swept_reg5", rdata[63:0], 64'h0);
        check("swept_busy31", 64'(rd_busy[1]), 64'd0);
        check("swept_reg31", rdata[127:64], 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
